// File: rtl/prog_loader.sv
// Byte-stream boot loader: parses MAGIC/LEN/data/CSUM frames from a valid/ready
// stream into program RAM and releases the CPU reset only after a checksum-verified load.
module prog_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte is consumed at a posedge where rx_valid & rx_ready are both 1;
  // rx_ready is 0 only while reset is asserted, so the sender may stream one byte per cycle.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int CW = ADDR_W + 1;

  state_t            r_state;
  logic [CW-1:0]     r_len;
  logic [CW-1:0]     r_count;
  logic [7:0]        r_sum;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic [CW-1:0]     w_len_byte;
  logic [CW-1:0]     w_count_nxt;
  logic [7:0]        w_sum_nxt;

  assign w_accept    = rx_valid & r_rx_ready;
  // A length byte of zero encodes a full-memory image of 2**ADDR_W bytes.
  assign w_len_byte  = (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : CW'(rx_data);
  assign w_count_nxt = r_count + CW'(1);
  assign w_sum_nxt   = r_sum + rx_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      r_mem_we   <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (rx_data == MAGIC) begin
              r_state     <= S_LEN;
              r_busy      <= 1'b1;
              r_cpu_reset <= 1'b1;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
            end
          end
          S_LEN: begin
            r_len   <= w_len_byte;
            r_count <= '0;
            r_sum   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_count[ADDR_W-1:0];
            r_mem_wdata <= rx_data;
            r_sum       <= w_sum_nxt;
            r_count     <= w_count_nxt;
            if (w_count_nxt == r_len) r_state <= S_CSUM;
          end
          S_CSUM: begin
            r_busy <= 1'b0;
            if (w_sum_nxt == 8'd0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are generated whole, expected RAM writes queued up front,
// and a negedge monitor pops them as mem_we pulses appear.
module tb_prog_loader;

  localparam logic [7:0] MAGIC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  prog_loader #(.ADDR_W(8), .MAGIC(MAGIC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          gaps_on  = 1'b0;
  logic [7:0]  fr_data[256];
  // Reference view of the loader's status after the last completed frame
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  bit          m_cpu_reset = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_errors++;
          $display("FAIL mem_write: got %0h/%0h expected %0h/%0h", mem_addr, mem_wdata, e[15:8], e[7:0]);
        end
      end
    end
    if (busy === 1'b1) begin
      n_checks++;
      if (cpu_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL cpu_reset_while_busy: got %0b expected 1", cpu_reset);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int g;
    int t;
    g = gaps_on ? $urandom_range(0, 3) : 0;
    rx_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    if (rx_ready !== 1'b1) chk("rx_ready_timeout", rx_ready, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_cs(input int n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n; i++) s = s + fr_data[i];
    return 8'd0 - s;
  endfunction

  // Sends MAGIC, LEN, fr_data[0..n-1], cs and checks the resulting status.
  task automatic send_frame(input int n, input logic [7:0] cs, input string tag);
    int s;
    logic [7:0] lb;
    lb = n[7:0];
    send_byte(MAGIC);
    send_byte(lb);
    chk({tag, "_busy_in_frame"}, busy, 1);
    chk({tag, "_done_cleared"}, done, 0);
    s = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = i[7:0];
      exp_q.push_back({a, fr_data[i]});
      s += fr_data[i];
      send_byte(fr_data[i]);
    end
    send_byte(cs);
    if (((s + cs) % 256) == 0) begin
      m_done = 1'b1; m_err = 1'b0; m_cpu_reset = 1'b0;
    end else begin
      m_done = 1'b0; m_err = 1'b1; m_cpu_reset = 1'b1;
    end
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_cpu_reset"}, cpu_reset, m_cpu_reset);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    reset = 1'b1;
    m_done = 1'b0; m_err = 1'b0; m_cpu_reset = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rx_ready_after"}, rx_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    do_reset(3, "reset");
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);

    // Back-to-back good 3-byte frame
    fr_data[0] = 8'h01; fr_data[1] = 8'h02; fr_data[2] = 8'h03;
    send_frame(3, 8'hFA, "frame3");

    // Bad checksum, then a recovering frame
    fr_data[0] = 8'h10; fr_data[1] = 8'h20;
    send_frame(2, 8'h00, "badcs");
    fr_data[0] = 8'h7F;
    send_frame(1, 8'h81, "retry");

    // Junk in IDLE is dropped; MAGIC inside a frame is plain data
    do_reset(1, "reset2");
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    repeat (2) @(posedge clk); #1;
    chk("junk_no_start", busy, 0);
    fr_data[0] = MAGIC;
    send_frame(1, 8'h5B, "magic_data");

    // Full 256-byte image (LEN byte 0)
    for (int i = 0; i < 256; i++) fr_data[i] = 8'h01;
    send_frame(256, 8'h00, "full");

    // Reset in the middle of a 4-byte frame
    send_byte(MAGIC); send_byte(8'h04);
    exp_q.push_back({8'h00, 8'h11}); send_byte(8'h11);
    exp_q.push_back({8'h01, 8'h22}); send_byte(8'h22);
    do_reset(1, "midreset");
    send_byte(8'h33); send_byte(8'h44);
    repeat (3) @(posedge clk); #1;
    chk("midreset_ignored_busy", busy, 0);
    chk("midreset_ignored_cpu_reset", cpu_reset, 1);

    // Randomized frames with gaps, junk between frames, occasional bad checksum
    gaps_on = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int n;
      int junk;
      logic [7:0] cs;
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == MAGIC) b = 8'h5A;
        send_byte(b);
      end
      chk("rand_junk_done", done, m_done);
      chk("rand_junk_err", err, m_err);
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        fr_data[i] = ($urandom_range(0, 7) == 0) ? MAGIC : 8'($urandom_range(0, 255));
      cs = good_cs(n);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      send_frame(n, cs, "rand");
    end

    repeat (4) @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
